// File: rtl/ifetch_queue.sv
// ifetch_queue
//
// Instruction-fetch front end placed directly upstream of the 2-way I-cache.
// It owns the fetch PC, drives the cache lookup (ic_paddr / ic_req), keeps a
// one-line buffer so sequential words of the same 128-bit line are served
// without another cache lookup, and queues {pc, instr} pairs in a small FIFO
// that decode drains.
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   ic_paddr   [31:0] fetch address to the cache (always the fetch PC)
//   ic_req            cache lookup request (combinational)
//   ic_rdata_line[127:0] line from the cache, valid when ic_req && !ic_stall
//   ic_stall          cache miss / refill in progress for ic_paddr
//   redirect_valid    retarget fetch; flushes the FIFO
//   redirect_pc[31:0] new fetch address (bits [1:0] forced to 0)
//   lb_flush          invalidate the line buffer (fence.i)
//   if_valid          FIFO head valid
//   if_instr   [31:0] head instruction
//   if_pc      [31:0] head PC
//   if_ready          decode accepts the head
//
// Handshake: the head entry transfers on a cycle where if_valid && if_ready
// are both high at the rising edge. if_valid never depends combinationally on
// if_ready, and if_instr/if_pc hold steady while if_valid is high and
// if_ready is low. A redirect in the same cycle cancels the transfer.

module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic [31:0]  ic_paddr,
  output logic         ic_req,
  input  logic [127:0] ic_rdata_line,
  input  logic         ic_stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         lb_flush,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc,
  input  logic         if_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  // Fetch state and line buffer
  logic [31:0]  fetch_pc;
  logic         lb_valid;
  logic [27:0]  lb_addr;
  logic [127:0] lb_data;

  // Instruction FIFO storage
  logic [31:0]   pc_mem    [QDEPTH];
  logic [31:0]   instr_mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Per-cycle decisions
  logic        full;
  logic        lb_hit;
  logic        push;
  logic        pop;
  logic        capture;
  logic [1:0]  word_sel;
  logic [31:0] lb_word;
  logic [31:0] line_word;
  logic [31:0] push_instr;
  logic [31:0] redirect_target;

  assign full     = (count == CW'(QDEPTH));
  assign lb_hit   = lb_valid && (lb_addr == fetch_pc[31:4]);
  assign word_sel = fetch_pc[3:2];

  // Masking keeps every redirect_pc bit on a real path; the low two bits are
  // simply cleared.
  assign redirect_target = redirect_pc & ~32'h0000_0003;

  // Lookup is suppressed while the queue is full, while a redirect is
  // pending (the address is about to change) and when the line buffer
  // already holds the word.
  assign ic_req   = !rst && !full && !redirect_valid && !lb_hit;
  assign ic_paddr = fetch_pc;

  // A line-buffer hit pushes without the cache; otherwise the push waits for
  // the first cycle the cache is not stalling. A pop never frees a slot for
  // a push in the same cycle.
  assign push    = !redirect_valid && !full && (lb_hit || !ic_stall);
  assign capture = push && !lb_hit;
  assign pop     = if_valid && if_ready && !redirect_valid;

  always_comb begin
    lb_word   = 32'h0;
    line_word = 32'h0;
    case (word_sel)
      2'd0: begin
        lb_word   = lb_data[31:0];
        line_word = ic_rdata_line[31:0];
      end
      2'd1: begin
        lb_word   = lb_data[63:32];
        line_word = ic_rdata_line[63:32];
      end
      2'd2: begin
        lb_word   = lb_data[95:64];
        line_word = ic_rdata_line[95:64];
      end
      default: begin
        lb_word   = lb_data[127:96];
        line_word = ic_rdata_line[127:96];
      end
    endcase
  end

  assign push_instr = lb_hit ? lb_word : line_word;

  // Fetch PC and line buffer. The line buffer survives redirects; only
  // lb_flush clears it, and a flush beats a capture in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      lb_valid <= 1'b0;
      lb_addr  <= 28'h0;
      lb_data  <= 128'h0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_target;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      if (capture) begin
        lb_data <= ic_rdata_line;
        lb_addr <= fetch_pc[31:4];
      end

      if (lb_flush) begin
        lb_valid <= 1'b0;
      end else if (capture) begin
        lb_valid <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy. A redirect discards every queued entry and
  // any transfer in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem[i]    <= 32'h0;
        instr_mem[i] <= 32'h0;
      end
    end else if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= push_instr;
    end
  end

  assign if_valid = (count != '0);
  assign if_pc    = pc_mem[rd_ptr];
  assign if_instr = instr_mem[rd_ptr];

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the 2-way instruction cache.
- Owns the fetch PC and drives the cache's paddr/req pair. When the cache does not stall, it captures the 128-bit line.
- Keeps a one-line buffer, so sequential words in the same line are served without re-requesting the cache.
- Pushes {pc, instr} pairs into a small FIFO that decode drains with a valid/ready handshake.
- Redirects from the back end flush the FIFO and retarget the fetch PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- QDEPTH, 4, instruction FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ic_paddr  out  32  fetch address to the cache; always equals fetch_pc.
- ic_req  out  1  cache lookup request.
- ic_rdata_line  in  128  line data from the cache; valid in the same cycle as ic_req && !ic_stall.
- ic_stall  in  1  cache miss / refill in progress for ic_paddr.
- redirect_valid  in  1  fetch retarget, e.g. branch mispredict or exception.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- lb_flush  in  1  invalidate the line buffer (fence.i).
- if_valid  out  1  FIFO head is valid.
- if_instr  out  32  head instruction.
- if_pc  out  32  head PC.
- if_ready  in  1  decode accepts the head.

Behaviour:
- Reset (async, while rst=1):
  - fetch_pc=RESET_PC, FIFO empty, lb_valid=0, lb_addr=0, lb_data=0.
  - ic_req=0, if_valid=0, if_instr=0, if_pc=0.
- Derived signals:
  - full = (count==QDEPTH).
  - lb_hit = lb_valid && (lb_addr==fetch_pc[31:4]).
  - word select w = fetch_pc[3:2]; word k = line[32k+31:32k], little-endian within the line.
- ic_req is combinational: ic_req = !rst && !full && !redirect_valid && !lb_hit.
- ic_paddr = fetch_pc at all times, including during reset. It stays stable across a stall because fetch_pc only moves on push or redirect.
- Push sources, evaluated each cycle with no redirect_valid and !full:
  - lb_hit: push {fetch_pc, lb_data word w}; fetch_pc += 4; no cache request.
  - else if !ic_stall (ic_req is high): push {fetch_pc, ic_rdata_line word w}; lb_data <= ic_rdata_line; lb_addr <= fetch_pc[31:4]; lb_valid <= 1; fetch_pc += 4.
  - else (miss): no push; hold fetch_pc; keep ic_req high until ic_stall drops.
- At most one push per cycle. The PC increment wraps modulo 2^32; on a wrap, lb_addr no longer matches and the cache is re-requested.
- Pop: if_valid && if_ready removes the head. A pop and a push in the same cycle leave count unchanged.
- No push bypass when full: a full FIFO blocks the push even if a pop occurs that cycle.
- Outputs: if_valid = (count!=0); if_instr and if_pc are the head entry, registered storage, with no combinational path from inputs.
- Redirect (redirect_valid=1), highest priority:
  - Next cycle: FIFO empty, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any push and any pop in that cycle are discarded.
  - The line buffer is kept; it stays valid and correct.
  - A cache refill already in flight completes inside the cache. Fetch simply presents the new address next cycle; a same-index miss waits for the cache to finish the prior refill.
- lb_flush: lb_valid <= 0 next cycle.
  - lb_flush together with a capture in the same cycle: the flush wins, so lb_valid=0.
  - The push of the captured word still happens.
- Latency:
  - Cache hit: ic_req in cycle N, entry visible on if_valid at N+1.
  - Line-buffer hit: entry pushed in the same cycle, visible at N+1.
  - Miss: push occurs in the first cycle ic_stall is low.
- Reset mid-miss: everything returns to reset values immediately; ic_req drops asynchronously.
- FIFO pointers are log2(QDEPTH) bits wide and wrap naturally; the count is log2(QDEPTH)+1 bits wide.

Test Plan:
- Sequential hits: cache always hits; line at 0x0 = {w3=0x33,w2=0x22,w1=0x11,w0=0x00}; if_ready=1 -> if_pc 0x0,0x4,0x8,0xC with instr 0x00,0x11,0x22,0x33 on consecutive cycles; ic_req high only on the 0x0 cycle and again at 0x10.
- Miss: ic_stall held 5 cycles at paddr 0x40 -> ic_paddr stays 0x40, ic_req stays 1, no push; first push in the cycle ic_stall falls; if_pc=0x40 the cycle after.
- Backpressure: if_ready=0, QDEPTH=4 -> after 4 pushes ic_req=0, fetch_pc=0x10, if_pc stays 0x0; raise if_ready -> drains in order 0x0..0xC, fetch resumes at 0x10.
- Redirect during miss: stall at 0x80, redirect_valid=1 with redirect_pc=0x107 -> next cycle FIFO empty, ic_paddr=0x104; first pushed if_pc=0x104 with line word 1.
- Simultaneous redirect + pop + push: the push and the pop that cycle are dropped; if_valid=0 next cycle.
- lb_flush: line 0x0 buffered, redirect to 0x0, lb_flush=1 -> ic_req re-asserted at 0x0 instead of a line-buffer hit.
- Async reset mid-operation: all outputs 0 and ic_paddr=RESET_PC within the reset assertion.
